// File: rtl/sram_like_data_mem_if.sv
// Request/response bundle between a data cache (master) and the SRAM-like responder (slave).
// Write data arrives lane-aligned; read data is always the full 32-bit word.
interface sram_like_data_mem_if;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata;
  logic        cache_data_addr_ok;
  logic        cache_data_data_ok;

  modport master (
    output cache_data_req, cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata,
    input  cache_data_rdata, cache_data_addr_ok, cache_data_data_ok
  );

  modport slave (
    input  cache_data_req, cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata,
    output cache_data_rdata, cache_data_addr_ok, cache_data_data_ok
  );
endinterface

// File: rtl/sram_like_data_mem.sv
// SRAM-like data-side responder with configurable address-accept and data-return delays.
// One transaction in flight; the word array is not reset and aliases modulo its depth.
module sram_like_data_mem #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_DELAY = 2,
  parameter int DATA_DELAY = 3
) (
  input logic               i_clk,
  input logic               i_rst_n,
  sram_like_data_mem_if.slave s_bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] AD_M1 = 4'(ADDR_DELAY - 1);
  localparam logic [3:0] DD_M1 = 4'(DATA_DELAY - 1);
  localparam bit AD_ZERO = (ADDR_DELAY == 32'sd0);
  localparam bit DD_ZERO = (DATA_DELAY == 32'sd0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AWAIT = 2'd1,
    S_DWAIT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_wr;
  logic [1:0]              r_size;
  logic [1:0]              r_lane;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;
  logic                    r_data_ok;
  logic [31:0]             r_mem [0:DEPTH-1];

  logic                    w_accept;
  logic [DEPTH_LOG2-1:0]   w_in_idx;
  logic [3:0]              w_be;

  assign w_in_idx = s_bus.cache_data_addr[DEPTH_LOG2+1:2];

  // Acceptance is combinational so a zero address delay answers in the request cycle; reset masks it.
  always_comb begin
    w_accept = 1'b0;
    if (i_rst_n && s_bus.cache_data_req) begin
      if (r_state == S_IDLE) begin
        w_accept = AD_ZERO;
      end else if (r_state == S_AWAIT) begin
        w_accept = (r_cnt == 4'd0);
      end else begin
        w_accept = 1'b0;
      end
    end else begin
      w_accept = 1'b0;
    end
  end

  // Byte-lane enables of the captured write.
  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  assign s_bus.cache_data_addr_ok = w_accept;
  assign s_bus.cache_data_data_ok = r_data_ok;
  assign s_bus.cache_data_rdata   = r_rdata;

  // Transaction FSM; rdata is loaded on entry to RESP so it is valid alongside data_ok.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_lane    <= 2'd0;
      r_idx     <= '0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_data_ok <= 1'b0;
    end else begin
      r_data_ok <= 1'b0;
      if (w_accept) begin
        r_wr    <= s_bus.cache_data_wr;
        r_size  <= s_bus.cache_data_size;
        r_lane  <= s_bus.cache_data_addr[1:0];
        r_idx   <= w_in_idx;
        r_wdata <= s_bus.cache_data_wdata;
        if (DD_ZERO) begin
          r_state   <= S_RESP;
          r_data_ok <= 1'b1;
          if (!s_bus.cache_data_wr) begin
            r_rdata <= r_mem[w_in_idx];
          end
        end else begin
          r_cnt   <= DD_M1;
          r_state <= S_DWAIT;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (s_bus.cache_data_req) begin
              r_cnt   <= AD_M1;
              r_state <= S_AWAIT;
            end
          end
          S_AWAIT: begin
            if (!s_bus.cache_data_req) begin
              r_cnt   <= 4'd0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_DWAIT: begin
            if (r_cnt == 4'd0) begin
              r_state   <= S_RESP;
              r_data_ok <= 1'b1;
              if (!r_wr) begin
                r_rdata <= r_mem[r_idx];
              end
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_RESP:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Array write commits at the end of a write RESP; a reset before that edge leaves RESP and cancels it.
  always_ff @(posedge i_clk) begin
    if (r_state == S_RESP && r_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
